// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw inputs in, clean pulses and debounced levels out.
interface button_conditioner_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] buttons_in;
  logic [WIDTH-1:0] buttons_pulse;
  logic [WIDTH-1:0] buttons_level;

  modport master (
    output buttons_in,
    input  buttons_pulse,
    input  buttons_level
  );

  modport slave (
    input  buttons_in,
    output buttons_pulse,
    output buttons_level
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-bit synchronizer, tick-sampled saturating debouncer and rising-edge detector
// producing one single-cycle pulse per accepted button press.
module button_conditioner #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned SAMPLE_CNT_MAX = 62500,
  parameter int unsigned PULSE_CNT_MAX  = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);
  localparam int unsigned SCW = $clog2(SAMPLE_CNT_MAX) + 1;
  localparam int unsigned PCW = $clog2(PULSE_CNT_MAX) + 1;
  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PCW-1:0] PULSE_FULL  = PCW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0]           sync1_q, sync1_d;
  logic [WIDTH-1:0]           sync2_q, sync2_d;
  logic [SCW-1:0]             sample_cnt_q, sample_cnt_d;
  logic [WIDTH-1:0][PCW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]           prev_q, prev_d;
  logic [WIDTH-1:0]           pulse_q, pulse_d;
  logic [WIDTH-1:0]           level;
  logic                       sample_tick;

  always_comb begin
    sync1_d      = bus.buttons_in;
    sync2_d      = sync1_q;
    sample_tick  = (sample_cnt_q == SAMPLE_LAST);
    sample_cnt_d = sample_tick ? '0 : sample_cnt_q + SCW'(1);
  end

  // Any low sample aborts a press; increments only on ticks and saturate at full.
  always_comb begin
    cnt_d = cnt_q;
    level = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      level[i] = (cnt_q[i] == PULSE_FULL);
      if (!sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (sample_tick && !level[i]) begin
        cnt_d[i] = cnt_q[i] + PCW'(1);
      end
    end
  end

  always_comb begin
    prev_d  = level;
    pulse_d = level & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sample_cnt_q <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      pulse_q      <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sample_cnt_q <= sample_cnt_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      pulse_q      <= pulse_d;
    end
  end

  assign bus.buttons_level = level;
  assign bus.buttons_pulse = pulse_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a cycle-level behavioural model.
module tb_button_conditioner;
  localparam int unsigned W = 4;
  localparam int unsigned S = 4;
  localparam int unsigned P = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_conditioner_if #(.WIDTH(W)) bus ();

  button_conditioner #(
    .WIDTH(W),
    .SAMPLE_CNT_MAX(S),
    .PULSE_CNT_MAX(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model state: edges since reset (tick phase), synchronized input
  // pipeline, qualifying-tick tally per bit and the previous debounced level.
  int unsigned      m_edges;
  logic [W-1:0]     m_s1, m_s2;
  int unsigned      m_hc [W];
  logic [W-1:0]     m_lvl_prev;
  logic [W-1:0]     m_pulse;

  int unsigned      cyc = 0;
  int unsigned      npulse [W];
  int unsigned      pulse_cyc [W];
  int unsigned      model_pulses = 0;
  int unsigned      dut_pulses = 0;
  logic             level_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_level();
    logic [W-1:0] l;
    for (int i = 0; i < W; i++) l[i] = (m_hc[i] == P);
    return l;
  endfunction

  task automatic model_clear();
    m_edges = 0; m_s1 = '0; m_s2 = '0; m_lvl_prev = '0; m_pulse = '0;
    for (int i = 0; i < W; i++) m_hc[i] = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] b);
    logic [W-1:0] lv;
    logic         tick;
    lv   = m_level();
    tick = ((m_edges % S) == S - 1);
    m_pulse    = lv & ~m_lvl_prev;
    m_lvl_prev = lv;
    for (int i = 0; i < W; i++) begin
      if (!m_s2[i])               m_hc[i] = 0;
      else if (tick && m_hc[i] < P) m_hc[i] = m_hc[i] + 1;
    end
    m_s2 = m_s1;
    m_s1 = b;
    m_edges++;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      npulse[i] = 0;
      pulse_cyc[i] = 0;
    end
    level_seen = 1'b0;
  endtask

  task automatic step(input logic [W-1:0] b);
    bus.buttons_in = b;
    @(posedge clk);
    cyc++;
    if (!rst) model_edge(b);
    @(negedge clk);
    chk("pulse", 32'(bus.buttons_pulse), 32'(m_pulse));
    chk("level", 32'(bus.buttons_level), 32'(m_level()));
    for (int i = 0; i < W; i++) begin
      if (bus.buttons_pulse[i]) begin
        npulse[i]++;
        pulse_cyc[i] = cyc;
        dut_pulses++;
      end
    end
    for (int i = 0; i < W; i++) if (m_pulse[i]) model_pulses++;
    if (bus.buttons_level != '0) level_seen = 1'b1;
  endtask

  task automatic do_reset(input int n, input logic [W-1:0] b);
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_pulse", 32'(bus.buttons_pulse), 32'd0);
    chk("rst_level", 32'(bus.buttons_level), 32'd0);
    for (int k = 0; k < n; k++) step(b);
    rst = 1'b0;
  endtask

  int unsigned  start;
  logic [W-1:0] rb;

  initial begin
    bus.buttons_in = '0;
    model_clear();
    clear_counts();
    @(negedge clk);

    // Clean press on bit 0
    do_reset(2, '0);
    clear_counts();
    start = cyc + 1;
    for (int k = 0; k < 40; k++) step(4'b0001);
    chk("clean_cnt0", npulse[0], 1);
    chk("clean_other", npulse[1] + npulse[2] + npulse[3], 0);
    chk("clean_win", 32'((pulse_cyc[0] - start >= 11) && (pulse_cyc[0] - start <= 14)), 1);
    chk("clean_lvl", 32'(bus.buttons_level), 32'b0001);
    for (int k = 0; k < 6; k++) step('0);

    // Bounce on bit 1
    clear_counts();
    for (int k = 0; k < 60; k++) step(((k / 3) % 2 == 0) ? 4'b0010 : 4'b0000);
    chk("bounce_pulse", npulse[1], 0);
    chk("bounce_lvl", 32'(level_seen), 0);

    // Release and re-press on bit 2
    clear_counts();
    for (int k = 0; k < 30; k++) step(4'b0100);
    chk("rp_first", npulse[2], 1);
    for (int k = 0; k < 3; k++) step('0);
    chk("rp_fall", 32'(bus.buttons_level[2]), 0);
    for (int k = 0; k < 7; k++) step('0);
    chk("rp_norel", npulse[2], 1);
    for (int k = 0; k < 30; k++) step(4'b0100);
    chk("rp_total", npulse[2], 2);
    for (int k = 0; k < 6; k++) step('0);

    // Simultaneous press on bits 1 and 3
    clear_counts();
    for (int k = 0; k < 30; k++) step(4'b1010);
    chk("sim_cnt1", npulse[1], 1);
    chk("sim_cnt3", npulse[3], 1);
    chk("sim_same", pulse_cyc[1], pulse_cyc[3]);
    for (int k = 0; k < 6; k++) step('0);

    // Reset while bit 0 is held
    clear_counts();
    for (int k = 0; k < 8; k++) step(4'b0001);
    chk("rmid_pre", npulse[0], 0);
    do_reset(2, 4'b0001);
    chk("rmid_during", npulse[0], 0);
    start = cyc + 1;
    for (int k = 0; k < 20; k++) step(4'b0001);
    chk("rmid_cnt", npulse[0], 1);
    chk("rmid_win", 32'((pulse_cyc[0] - start >= 11) && (pulse_cyc[0] - start <= 14)), 1);
    for (int k = 0; k < 6; k++) step('0);

    // Long hold on bit 3
    clear_counts();
    for (int k = 0; k < 1000; k++) step(4'b1000);
    chk("long_cnt", npulse[3], 1);
    chk("long_lvl", 32'(bus.buttons_level), 32'b1000);
    for (int k = 0; k < 6; k++) step('0);

    // Random bouncing and holding on all bits
    rb = '0;
    model_pulses = 0;
    dut_pulses = 0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
      step(rb);
    end
    chk("rand_total", dut_pulses, model_pulses);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
